instruction_fetch: RTL

//  Owns the program counter and fetches 32-bit instructions from instruction memory.

---
 rtl/instruction_fetch.sv | 115 +++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues one outstanding memory read at a time and
// hands each instruction with its PC to decode; honours redirects from branch resolution.
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_request_valid,
  input  logic        mem_request_ready,
  output logic [31:0] mem_request_address,
  input  logic        mem_response_valid,
  input  logic [31:0] mem_response_data,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] instruction,
  output logic [31:0] instruction_program_counter,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_program_counter,
  output logic        fetch_misaligned_error
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    REQUEST       = 2'd0,
    WAIT_RESPONSE = 2'd1,
    HOLD          = 2'd2,
    ERROR         = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            discard;
  logic            misaligned_c;

  assign misaligned_c        = redirect_program_counter[1:0] != 2'b00;
  assign mem_request_address = pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                       <= REQUEST;
      pc                          <= RESET_VECTOR;
      discard                     <= 1'b0;
      mem_request_valid           <= 1'b1;
      instruction_valid           <= 1'b0;
      instruction                 <= '0;
      instruction_program_counter <= '0;
      fetch_misaligned_error      <= 1'b0;
    end else if (redirect_valid && state != ERROR && misaligned_c) begin
      // Bad target: stop fetching for good, any in-flight response is ignored
      state                  <= ERROR;
      discard                <= 1'b0;
      mem_request_valid      <= 1'b0;
      instruction_valid      <= 1'b0;
      fetch_misaligned_error <= 1'b1;
    end else begin
      case (state)
        REQUEST: begin
          if (redirect_valid) begin
            pc <= redirect_program_counter;
          end
          if (mem_request_ready) begin
            state             <= WAIT_RESPONSE;
            mem_request_valid <= 1'b0;
            // The accepted request fetched the old path
            if (redirect_valid) begin
              discard <= 1'b1;
            end
          end
        end
        WAIT_RESPONSE: begin
          if (redirect_valid) begin
            pc <= redirect_program_counter;
            if (mem_response_valid) begin
              state             <= REQUEST;
              mem_request_valid <= 1'b1;
              discard           <= 1'b0;
            end else begin
              discard <= 1'b1;
            end
          end else if (mem_response_valid) begin
            if (discard) begin
              state             <= REQUEST;
              mem_request_valid <= 1'b1;
              discard           <= 1'b0;
            end else begin
              state                       <= HOLD;
              instruction                 <= mem_response_data;
              instruction_program_counter <= pc;
              instruction_valid           <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc                <= redirect_program_counter;
            instruction_valid <= 1'b0;
            state             <= REQUEST;
            mem_request_valid <= 1'b1;
          end else if (instruction_ready) begin
            pc                <= pc + XLEN'(4);
            instruction_valid <= 1'b0;
            state             <= REQUEST;
            mem_request_valid <= 1'b1;
          end
        end
        default: begin
          mem_request_valid <= 1'b0;
          instruction_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
